// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern generator: state encoding, default
// symbols and repetition-counter width.
package pattern_pkg;

  localparam int CNT_W = 4;
  localparam int SYM_W = 9;

  localparam logic [SYM_W-1:0] DEF_SYM_A = 9'd3;
  localparam logic [SYM_W-1:0] DEF_SYM_B = 9'd9;
  localparam logic [SYM_W-1:0] DEF_FILL  = 9'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_GAP  = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

endpackage

// File: rtl/pattern_rep_counter.sv
// Repetition down-counter: loaded at burst start, decremented once per
// completed pattern; flags when empty and when on the final repetition.
module pattern_rep_counter
  import pattern_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/pattern_generator3393.sv
// Burst pattern generator emitting SYM_A,SYM_A,SYM_B,SYM_A per repetition.
// Define PATTERN_GAP_EN to insert one FILL symbol (valid) between repetitions.
//
// state | meaning
// IDLE  | waiting for start, outputs FILL
// P0    | emit SYM_A, first symbol of a repetition
// P1    | emit SYM_A
// P2    | emit SYM_B
// P3    | emit SYM_A, last symbol; repetition counted on acceptance
// GAP   | emit FILL with valid between repetitions (PATTERN_GAP_EN only)
// FIN   | one-cycle done pulse, then IDLE
module pattern_generator3393
  import pattern_pkg::*;
#(
  parameter logic [SYM_W-1:0] SYM_A = DEF_SYM_A,
  parameter logic [SYM_W-1:0] SYM_B = DEF_SYM_B,
  parameter logic [SYM_W-1:0] FILL  = DEF_FILL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  input  logic             ready,
  output logic [SYM_W-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  state_t state_q, state_n;
  logic   rep_load, rep_dec, rep_clear;
  logic   rep_zero, rep_last;

  pattern_rep_counter u_rep_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rep_load),
    .dec      (rep_dec),
    .clear    (rep_clear),
    .load_val (count),
    .zero     (rep_zero),
    .last     (rep_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    rep_load = 1'b0;
    rep_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          rep_load = 1'b1;
          state_n  = (count != '0) ? ST_P0 : ST_FIN;
        end
      end
      ST_P0: if (ready) state_n = ST_P1;
      ST_P1: if (ready) state_n = ST_P2;
      ST_P2: if (ready) state_n = ST_P3;
      ST_P3: begin
        if (ready) begin
          rep_dec = 1'b1;
          // zero is a guard only; a running burst always holds count >= 1
          if (rep_last || rep_zero) begin
            state_n = ST_FIN;
          end else begin
`ifdef PATTERN_GAP_EN
            state_n = ST_GAP;
`else
            state_n = ST_P0;
`endif
          end
        end
      end
`ifdef PATTERN_GAP_EN
      ST_GAP: if (ready) state_n = ST_P0;
`endif
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // abort overrides every other request once a burst is running
    if (abort && state_q != ST_IDLE) begin
      state_n = ST_IDLE;
      rep_dec = 1'b0;
    end
  end

  assign rep_clear = abort && (state_q != ST_IDLE);

  always_comb begin
    data_out = FILL;
    valid    = 1'b0;
    case (state_q)
      ST_P0, ST_P1, ST_P3: begin
        data_out = SYM_A;
        valid    = 1'b1;
      end
      ST_P2: begin
        data_out = SYM_B;
        valid    = 1'b1;
      end
`ifdef PATTERN_GAP_EN
      ST_GAP: begin
        data_out = FILL;
        valid    = 1'b1;
      end
`endif
      default: begin
        data_out = FILL;
        valid    = 1'b0;
      end
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_FIN);
  assign state = state_q;

endmodule

// File: tb/tb_pattern_generator3393.sv
// Directed table-driven bench for pattern_generator3393; expected rows are
// written out per cycle, with a hand-written mid-burst reset sequence.
module tb_pattern_generator3393;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_P1   = 3'd2;
  localparam logic [2:0] S_P2   = 3'd3;
  localparam logic [2:0] S_P3   = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, ready;
  logic [3:0] count;
  logic [8:0] data_out;
  logic       valid, busy, done;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       start;
    logic [3:0] count;
    logic       abort;
    logic       ready;
    logic [8:0] e_data;
    logic       e_valid;
    logic       e_busy;
    logic       e_done;
    logic [2:0] e_state;
  } vec_t;

  vec_t vecs[$];

  pattern_generator3393 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .count    (count),
    .abort    (abort),
    .ready    (ready),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input logic r, input logic s, input logic [3:0] c,
                              input logic a, input logic rd, input logic [8:0] d, input logic v,
                              input logic b, input logic dn, input logic [2:0] st);
    vec_t t;
    t.name = n; t.rst_n = r; t.start = s; t.count = c; t.abort = a; t.ready = rd;
    t.e_data = d; t.e_valid = v; t.e_busy = b; t.e_done = dn; t.e_state = st;
    return t;
  endfunction

  task automatic add(input string n, input logic r, input logic s, input logic [3:0] c,
                     input logic a, input logic rd, input logic [8:0] d, input logic v,
                     input logic b, input logic dn, input logic [2:0] st);
    vecs.push_back(mk(n, r, s, c, a, rd, d, v, b, dn, st));
  endtask

  // drive inputs, take one rising edge, compare outputs 1 time unit later
  task automatic apply(input vec_t t);
    rst_n = t.rst_n; start = t.start; count = t.count; abort = t.abort; ready = t.ready;
    @(posedge clk);
    #1;
    checks++;
    if ({data_out, valid, busy, done, state} !==
        {t.e_data, t.e_valid, t.e_busy, t.e_done, t.e_state}) begin
      failures++;
      $display("FAIL %s: got data=%0d valid=%0b busy=%0b done=%0b state=%0d, want data=%0d valid=%0b busy=%0b done=%0b state=%0d",
               t.name, data_out, valid, busy, done, state,
               t.e_data, t.e_valid, t.e_busy, t.e_done, t.e_state);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; count = 4'd0; abort = 1'b0; ready = 1'b0;

    // reset with start asserted must stay idle
    add("rst0",     0, 1, 4'd1, 0, 1, 9'd0, 0, 0, 0, S_IDLE);
    add("rst1",     0, 1, 4'd1, 0, 1, 9'd0, 0, 0, 0, S_IDLE);
    add("idle",     1, 0, 4'd1, 0, 1, 9'd0, 0, 0, 0, S_IDLE);
    // count=1 single burst: valid cycles 1-4, done cycle 5, idle cycle 6
    add("c1_p0",    1, 1, 4'd1, 0, 1, 9'd3, 1, 1, 0, S_P0);
    add("c1_p1",    1, 0, 4'd1, 0, 1, 9'd3, 1, 1, 0, S_P1);
    add("c1_p2",    1, 0, 4'd1, 0, 1, 9'd9, 1, 1, 0, S_P2);
    add("c1_p3",    1, 0, 4'd1, 0, 1, 9'd3, 1, 1, 0, S_P3);
    add("c1_fin",   1, 0, 4'd1, 0, 1, 9'd0, 0, 1, 1, S_FIN);
    add("c1_idle",  1, 0, 4'd1, 0, 1, 9'd0, 0, 0, 0, S_IDLE);
    // count=2, with start re-asserted and count changed while busy
    add("c2_p0",    1, 1, 4'd2, 0, 1, 9'd3, 1, 1, 0, S_P0);
    add("c2_p1",    1, 1, 4'd5, 0, 1, 9'd3, 1, 1, 0, S_P1);
    add("c2_p2",    1, 0, 4'd7, 0, 1, 9'd9, 1, 1, 0, S_P2);
    add("c2_p3",    1, 1, 4'd1, 0, 1, 9'd3, 1, 1, 0, S_P3);
`ifdef PATTERN_GAP_EN
    add("c2_gap",   1, 0, 4'd7, 0, 1, 9'd0, 1, 1, 0, S_GAP);
`endif
    add("c2_p0b",   1, 0, 4'd7, 0, 1, 9'd3, 1, 1, 0, S_P0);
    add("c2_p1b",   1, 0, 4'd7, 0, 1, 9'd3, 1, 1, 0, S_P1);
    add("c2_p2b",   1, 0, 4'd7, 0, 1, 9'd9, 1, 1, 0, S_P2);
    add("c2_p3b",   1, 0, 4'd7, 0, 1, 9'd3, 1, 1, 0, S_P3);
    add("c2_fin",   1, 0, 4'd7, 0, 1, 9'd0, 0, 1, 1, S_FIN);
    add("c2_idle",  1, 0, 4'd7, 0, 1, 9'd0, 0, 0, 0, S_IDLE);
    // ready low for 3 cycles while showing SYM_B
    add("st_p0",    1, 1, 4'd1, 0, 1, 9'd3, 1, 1, 0, S_P0);
    add("st_p1",    1, 0, 4'd1, 0, 1, 9'd3, 1, 1, 0, S_P1);
    add("st_p2",    1, 0, 4'd1, 0, 1, 9'd9, 1, 1, 0, S_P2);
    add("st_hold1", 1, 0, 4'd1, 0, 0, 9'd9, 1, 1, 0, S_P2);
    add("st_hold2", 1, 0, 4'd1, 0, 0, 9'd9, 1, 1, 0, S_P2);
    add("st_hold3", 1, 0, 4'd1, 0, 0, 9'd9, 1, 1, 0, S_P2);
    add("st_p3",    1, 0, 4'd1, 0, 1, 9'd3, 1, 1, 0, S_P3);
    add("st_fin",   1, 0, 4'd1, 0, 1, 9'd0, 0, 1, 1, S_FIN);
    add("st_idle",  1, 0, 4'd1, 0, 1, 9'd0, 0, 0, 0, S_IDLE);
    // count=3, abort (with start and ready high) in second repetition
    add("ab_p0",    1, 1, 4'd3, 0, 1, 9'd3, 1, 1, 0, S_P0);
    add("ab_p1",    1, 0, 4'd3, 0, 1, 9'd3, 1, 1, 0, S_P1);
    add("ab_p2",    1, 0, 4'd3, 0, 1, 9'd9, 1, 1, 0, S_P2);
    add("ab_p3",    1, 0, 4'd3, 0, 1, 9'd3, 1, 1, 0, S_P3);
`ifdef PATTERN_GAP_EN
    add("ab_gap",   1, 0, 4'd3, 0, 1, 9'd0, 1, 1, 0, S_GAP);
`endif
    add("ab_p0b",   1, 0, 4'd3, 0, 1, 9'd3, 1, 1, 0, S_P0);
    add("ab_p1b",   1, 0, 4'd3, 0, 1, 9'd3, 1, 1, 0, S_P1);
    add("ab_hit",   1, 1, 4'd3, 1, 1, 9'd0, 0, 0, 0, S_IDLE);
    add("ab_after", 1, 0, 4'd3, 0, 1, 9'd0, 0, 0, 0, S_IDLE);
    // abort in IDLE beats start
    add("ab_idle",  1, 1, 4'd2, 1, 1, 9'd0, 0, 0, 0, S_IDLE);
    // abort while stalled in P0
    add("ab2_p0",   1, 1, 4'd2, 0, 0, 9'd3, 1, 1, 0, S_P0);
    add("ab2_hold", 1, 0, 4'd2, 0, 0, 9'd3, 1, 1, 0, S_P0);
    add("ab2_hit",  1, 0, 4'd2, 1, 0, 9'd0, 0, 0, 0, S_IDLE);
    // count=0: no valid, done one cycle after start
    add("c0_fin",   1, 1, 4'd0, 0, 1, 9'd0, 0, 1, 1, S_FIN);
    add("c0_idle",  1, 0, 4'd0, 0, 1, 9'd0, 0, 0, 0, S_IDLE);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // mid-burst reset discards the burst; start seen during reset is ignored
    apply(mk("mr_p0",   1, 1, 4'd2, 0, 1, 9'd3, 1, 1, 0, S_P0));
    apply(mk("mr_p1",   1, 0, 4'd2, 0, 1, 9'd3, 1, 1, 0, S_P1));
    apply(mk("mr_rst",  0, 1, 4'd3, 0, 1, 9'd0, 0, 0, 0, S_IDLE));
    apply(mk("mr_idle", 1, 0, 4'd3, 0, 1, 9'd0, 0, 0, 0, S_IDLE));
    apply(mk("mr_idl2", 1, 0, 4'd3, 0, 1, 9'd0, 0, 0, 0, S_IDLE));
    // a fresh count=1 burst afterwards completes after one repetition
    apply(mk("mr_n_p0", 1, 1, 4'd1, 0, 1, 9'd3, 1, 1, 0, S_P0));
    apply(mk("mr_n_p1", 1, 0, 4'd1, 0, 1, 9'd3, 1, 1, 0, S_P1));
    apply(mk("mr_n_p2", 1, 0, 4'd1, 0, 1, 9'd9, 1, 1, 0, S_P2));
    apply(mk("mr_n_p3", 1, 0, 4'd1, 0, 1, 9'd3, 1, 1, 0, S_P3));
    apply(mk("mr_n_fn", 1, 0, 4'd1, 0, 1, 9'd0, 0, 1, 1, S_FIN));
    apply(mk("mr_n_id", 1, 0, 4'd1, 0, 1, 9'd0, 0, 0, 0, S_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
